// File: rtl/guess_game_ctrl_if.sv
// Board-side bundle for the guessing-game controller: buttons, switches,
// decoder patterns in; decoder value, segment bus, digit enables, flags out.
interface guess_game_ctrl_if;
  logic       btn_start;
  logic       btn_submit;
  logic [3:0] user_guess;
  logic [6:0] seg_first;
  logic [6:0] seg_second;
  logic [3:0] disp_val;
  logic [6:0] seg;
  logic [1:0] an;
  logic       led_high;
  logic       led_low;
  logic       led_win;
  logic       led_lose;
  logic       guess_err;
  logic [3:0] tries;

  modport master (
    output btn_start, btn_submit, user_guess,
    output seg_first, seg_second,
    input  disp_val, seg, an,
    input  led_high, led_low, led_win, led_lose,
    input  guess_err, tries
  );

  modport slave (
    input  btn_start, btn_submit, user_guess,
    input  seg_first, seg_second,
    output disp_val, seg, an,
    output led_high, led_low, led_win, led_lose,
    output guess_err, tries
  );
endinterface

// File: rtl/guess_game_ctrl.sv
// Number-guessing game sequencer: LFSR secret draw, guess FSM, result flags
// and 2-digit 7-seg scan. Ports: clk, rst_n (async low), bus (slave
// modport: buttons/switches/decoder patterns in, disp_val/seg/an/flags out).
// Optional GUESS_BLINK_EN: blink the display in WIN/LOSE every 256 scan wraps.
module guess_game_ctrl #(
  parameter int          SCAN_DIV  = 50000,
  parameter int          MAX_TRIES = 5,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  guess_game_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, PLAY, CHECK, WIN, LOSE
  } state_t;

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(SCAN_DIV - 1);
  localparam logic [3:0] TMAX = 4'(MAX_TRIES);

  state_t     state;
  logic [7:0] lfsr;
  logic       start_r, start_q;
  logic       sub_r, sub_q;
  logic       start_ev, sub_ev;
  logic [3:0] secret, guess_q, draw;
  logic [3:0] tries_q;
  logic       hi_q, lo_q, win_q, lose_q, err_q;
  logic [CW-1:0] cnt;
  logic       sel, wrap;
  logic [6:0] seg_q;
  logic [1:0] an_q;
  logic [3:0] disp;

  assign start_ev = start_r & ~start_q;
  assign sub_ev   = sub_r & ~sub_q;
  // fold 11..15 back into range so every draw is a legal secret
  assign draw = (lfsr[3:0] <= 4'd10) ? lfsr[3:0]
                                     : lfsr[3:0] - 4'd5;
  assign wrap = (cnt == CMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lfsr    <= LFSR_SEED;
      start_r <= 1'b0;
      start_q <= 1'b0;
      sub_r   <= 1'b0;
      sub_q   <= 1'b0;
      secret  <= 4'd0;
      guess_q <= 4'd0;
      tries_q <= 4'd0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      lfsr    <= {lfsr[6:0],
                  lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      start_r <= bus.btn_start;
      start_q <= start_r;
      sub_r   <= bus.btn_submit;
      sub_q   <= sub_r;
      err_q   <= 1'b0;
      if (start_ev) begin
        state   <= PLAY;
        secret  <= draw;
        tries_q <= 4'd0;
        hi_q    <= 1'b0;
        lo_q    <= 1'b0;
        win_q   <= 1'b0;
        lose_q  <= 1'b0;
      end else begin
        case (state)
          PLAY: begin
            if (sub_ev) begin
              if (bus.user_guess <= 4'd10) begin
                guess_q <= bus.user_guess;
                if (tries_q != TMAX)
                  tries_q <= tries_q + 4'd1;
                state <= CHECK;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          CHECK: begin
            hi_q <= 1'b0;
            lo_q <= 1'b0;
            if (guess_q == secret) begin
              state <= WIN;
              win_q <= 1'b1;
            end else if (tries_q == TMAX) begin
              state  <= LOSE;
              lose_q <= 1'b1;
            end else begin
              state <= PLAY;
              hi_q  <= (guess_q > secret);
              lo_q  <= (guess_q < secret);
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef GUESS_BLINK_EN
  logic [7:0] bcnt;
  logic       blink;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      sel   <= 1'b0;
      seg_q <= 7'h7F;
      an_q  <= 2'b11;
`ifdef GUESS_BLINK_EN
      bcnt  <= 8'd0;
      blink <= 1'b0;
`endif
    end else if (state == IDLE) begin
      cnt   <= '0;
      sel   <= 1'b0;
      seg_q <= 7'h7F;
      an_q  <= 2'b11;
`ifdef GUESS_BLINK_EN
      bcnt  <= 8'd0;
      blink <= 1'b0;
`endif
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap)
        sel <= ~sel;
      seg_q <= sel ? bus.seg_second : bus.seg_first;
      an_q  <= sel ? 2'b10 : 2'b01;
`ifdef GUESS_BLINK_EN
      // counters sit at zero outside WIN/LOSE, so each entry starts visible
      if (state == WIN || state == LOSE) begin
        if (wrap) begin
          bcnt <= bcnt + 8'd1;
          if (bcnt == 8'hFF)
            blink <= ~blink;
        end
        if (blink) begin
          seg_q <= 7'h7F;
          an_q  <= 2'b11;
        end
      end else begin
        bcnt  <= 8'd0;
        blink <= 1'b0;
      end
`endif
    end
  end

  always_comb begin
    disp = 4'd0;
    case (state)
      PLAY:     disp = bus.user_guess;
      CHECK:    disp = guess_q;
      WIN:      disp = secret;
      LOSE:     disp = secret;
      default:  disp = 4'd0;
    endcase
  end

  assign bus.disp_val  = disp;
  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.led_high  = hi_q;
  assign bus.led_low   = lo_q;
  assign bus.led_win   = win_q;
  assign bus.led_lose  = lose_q;
  assign bus.guess_err = err_q;
  assign bus.tries     = tries_q;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed self-checking bench for guess_game_ctrl
// (SCAN_DIV=4, MAX_TRIES=3, LFSR_SEED=8'hA5).
module tb_guess_game_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] model;

  guess_game_ctrl_if gif();

  guess_game_ctrl #(
    .SCAN_DIV  (4),
    .MAX_TRIES (3),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (gif.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lnext(input logic [7:0] m);
    return {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
  endfunction

  function automatic logic [3:0] sdraw(input logic [7:0] m);
    logic [3:0] v;
    v = m[3:0];
    return (v <= 4'd10) ? v : v - 4'd5;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) model <= 8'hA5;
    else        model <= lnext(model);

  task automatic do_reset();
    @(negedge clk);
    gif.btn_start  = 1'b0;
    gif.btn_submit = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // want < 0: start now; otherwise wait until the draw gives v == want
  task automatic start_game(input int want, output logic [3:0] sec);
    logic [7:0] nv;
    bit found;
    found = 0;
    nv = 8'h00;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      nv = lnext(model);
      if (want < 0 || int'(nv[3:0]) == want) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL start_wait: no lfsr v=%0d in budget", want);
    end
    sec = sdraw(nv);
    gif.btn_start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    gif.btn_start = 1'b0;
  endtask

  task automatic do_submit(input logic [3:0] g);
    @(negedge clk);
    gif.user_guess = g;
    gif.btn_submit = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    gif.btn_submit = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (gif.seg !== 7'h7F) begin
      failures++;
      $display("FAIL rst_seg: got %h want 7f", gif.seg);
    end
    checks++;
    if (gif.an !== 2'b11) begin
      failures++;
      $display("FAIL rst_an: got %b want 11", gif.an);
    end
    checks++;
    if (gif.tries !== 4'd0) begin
      failures++;
      $display("FAIL rst_tries: got %0d want 0", gif.tries);
    end
    checks++;
    if ({gif.led_high, gif.led_low, gif.led_win,
         gif.led_lose, gif.guess_err} !== 5'b0) begin
      failures++;
      $display("FAIL rst_flags: got %b want 00000",
        {gif.led_high, gif.led_low, gif.led_win,
         gif.led_lose, gif.guess_err});
    end
    checks++;
    if (gif.disp_val !== 4'd0) begin
      failures++;
      $display("FAIL rst_disp: got %0d want 0", gif.disp_val);
    end
  endtask

  task automatic test_scan();
    logic [3:0] sec;
    logic [1:0] ea;
    logic [6:0] es;
    gif.seg_first  = 7'h12;
    gif.seg_second = 7'h34;
    start_game(-1, sec);
    checks++;
    if (gif.an !== 2'b11) begin
      failures++;
      $display("FAIL scan_start_blank: got %b want 11", gif.an);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      ea = ((k / 4) % 2 == 1) ? 2'b10 : 2'b01;
      if (ea == 2'b10) es = 7'h34;
      else             es = (k >= 2) ? 7'h55 : 7'h12;
      checks++;
      if (gif.an !== ea || gif.seg !== es) begin
        failures++;
        $display("FAIL scan_k%0d: got an=%b seg=%h want an=%b seg=%h",
          k, gif.an, gif.seg, ea, es);
      end
      if (k == 1) gif.seg_first = 7'h55;
    end
  endtask

  task automatic test_win();
    logic [3:0] sec;
    start_game(13, sec);
    @(negedge clk);
    gif.user_guess = 4'd7;
    #1;
    checks++;
    if (gif.disp_val !== 4'd7) begin
      failures++;
      $display("FAIL win_live: got %0d want 7", gif.disp_val);
    end
    do_submit(4'd3);
    checks++;
    if (gif.led_low !== 1'b1 || gif.led_high !== 1'b0
        || gif.tries !== 4'd1) begin
      failures++;
      $display("FAIL win_g3: got lo=%b hi=%b tries=%0d want 1 0 1",
        gif.led_low, gif.led_high, gif.tries);
    end
    do_submit(4'd9);
    checks++;
    if (gif.led_high !== 1'b1 || gif.led_low !== 1'b0
        || gif.tries !== 4'd2) begin
      failures++;
      $display("FAIL win_g9: got hi=%b lo=%b tries=%0d want 1 0 2",
        gif.led_high, gif.led_low, gif.tries);
    end
    do_submit(4'd8);
    checks++;
    if (gif.led_win !== 1'b1 || gif.led_lose !== 1'b0
        || gif.disp_val !== 4'd8 || gif.tries !== 4'd3) begin
      failures++;
      $display("FAIL win_g8: got win=%b lose=%b disp=%0d tries=%0d want 1 0 8 3",
        gif.led_win, gif.led_lose, gif.disp_val, gif.tries);
    end
  endtask

  task automatic test_blink();
    int first;
    int lo_lim;
    int hi_lim;
    first = -1;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (gif.an === 2'b11 && first < 0) first = k;
    end
`ifdef GUESS_BLINK_EN
    lo_lim = 1000;
    hi_lim = 1040;
`else
    lo_lim = -1;
    hi_lim = -1;
`endif
    checks++;
    if (first < lo_lim || first > hi_lim) begin
      failures++;
      $display("FAIL blink: first blank at %0d want %0d..%0d",
        first, lo_lim, hi_lim);
    end
  endtask

  task automatic test_lose();
    logic [3:0] sec;
    logic [3:0] g;
    start_game(-1, sec);
    g = (sec >= 4'd5) ? 4'd0 : 4'd10;
    do_submit(g);
    do_submit(g);
    checks++;
    if (gif.led_lose !== 1'b0 || gif.tries !== 4'd2) begin
      failures++;
      $display("FAIL lose_2nd: got lose=%b tries=%0d want 0 2",
        gif.led_lose, gif.tries);
    end
    do_submit(g);
    checks++;
    if (gif.led_lose !== 1'b1 || gif.led_win !== 1'b0
        || gif.disp_val !== sec || gif.tries !== 4'd3) begin
      failures++;
      $display("FAIL lose_3rd: got lose=%b win=%b disp=%0d tries=%0d want 1 0 %0d 3",
        gif.led_lose, gif.led_win, gif.disp_val, gif.tries, sec);
    end
    do_submit(sec);
    checks++;
    if (gif.tries !== 4'd3 || gif.led_lose !== 1'b1
        || gif.led_win !== 1'b0) begin
      failures++;
      $display("FAIL lose_ignored: got tries=%0d lose=%b win=%b want 3 1 0",
        gif.tries, gif.led_lose, gif.led_win);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] sec;
    logic e;
    start_game(-1, sec);
    @(negedge clk);
    gif.user_guess = 4'd12;
    gif.btn_submit = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      e = (k == 2);
      checks++;
      if (gif.guess_err !== e) begin
        failures++;
        $display("FAIL illegal_err_k%0d: got %b want %b",
          k, gif.guess_err, e);
      end
      if (k == 1) begin
        checks++;
        if (gif.disp_val !== 4'd12) begin
          failures++;
          $display("FAIL illegal_disp: got %0d want 12", gif.disp_val);
        end
      end
    end
    gif.btn_submit = 1'b0;
    checks++;
    if (gif.tries !== 4'd0) begin
      failures++;
      $display("FAIL illegal_tries: got %0d want 0", gif.tries);
    end
  endtask

  task automatic test_priority();
    logic [3:0] sec;
    start_game(-1, sec);
    do_submit((sec >= 4'd5) ? 4'd0 : 4'd10);
    @(negedge clk);
    gif.user_guess = (sec >= 4'd5) ? 4'd1 : 4'd9;
    gif.btn_start  = 1'b1;
    gif.btn_submit = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (gif.tries !== 4'd0 || {gif.led_high, gif.led_low,
        gif.led_win, gif.led_lose} !== 4'b0) begin
      failures++;
      $display("FAIL priority: got tries=%0d flags=%b want 0 0000",
        gif.tries, {gif.led_high, gif.led_low,
        gif.led_win, gif.led_lose});
    end
    gif.btn_start  = 1'b0;
    gif.btn_submit = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] sec;
    start_game(-1, sec);
    do_submit((sec >= 4'd5) ? 4'd0 : 4'd10);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gif.tries !== 4'd0 || gif.seg !== 7'h7F || gif.an !== 2'b11
        || gif.disp_val !== 4'd0 || {gif.led_high, gif.led_low,
        gif.led_win, gif.led_lose} !== 4'b0) begin
      failures++;
      $display("FAIL reset_mid: got tries=%0d seg=%h an=%b disp=%0d flags=%b",
        gif.tries, gif.seg, gif.an, gif.disp_val,
        {gif.led_high, gif.led_low, gif.led_win, gif.led_lose});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    gif.btn_start  = 1'b0;
    gif.btn_submit = 1'b0;
    gif.user_guess = 4'd0;
    gif.seg_first  = 7'h12;
    gif.seg_second = 7'h34;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_scan();
    do_reset();
    test_win();
    test_blink();
    test_lose();
    test_illegal();
    test_priority();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
